// File: rtl/booth4_pp_gen.sv
// booth4_pp_gen: radix-4 Booth partial-product generator, 8x8 signed.
// Recodes one Booth digit per cycle into four weighted 16-bit products.
module booth4_pp_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  multiplicand,
   input  logic [7:0]  multiplier,
   output logic [15:0] pp1,
   output logic [15:0] pp2,
   output logic [15:0] pp3,
   output logic [15:0] pp4,
   output logic [3:0]  zero_mask,
   output logic        out_valid,
   input  logic        out_ready
);
   typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [7:0]  x;
   logic [7:0]  y;
   logic [8:0]  ye;
   logic [2:0]  trip;
   logic [15:0] xs;
   logic [15:0] mag;
   logic [15:0] term;
   logic [15:0] prod;
   logic        neg;
   logic        is_zero;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // ye[0] is the implicit Y[-1]=0 below the LSB
   assign ye   = {y, 1'b0};
   assign trip = ye[{cnt, 1'b0} +: 3];
   assign xs   = {{8{x[7]}}, x};

   always_comb begin
      mag     = '0;
      neg     = 1'b0;
      is_zero = 1'b0;
      unique case (trip)
         3'b001, 3'b010: mag = xs;
         3'b011:         mag = xs << 1;
         3'b100: begin
            mag = xs << 1;
            neg = 1'b1;
         end
         3'b101, 3'b110: begin
            mag = xs;
            neg = 1'b1;
         end
         default: is_zero = 1'b1;
      endcase
      term = neg ? (~mag + 16'd1) : mag;
      prod = term << {cnt, 1'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         x         <= '0;
         y         <= '0;
         pp1       <= '0;
         pp2       <= '0;
         pp3       <= '0;
         pp4       <= '0;
         zero_mask <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  x         <= multiplicand;
                  y         <= multiplier;
                  pp1       <= '0;
                  pp2       <= '0;
                  pp3       <= '0;
                  pp4       <= '0;
                  zero_mask <= '0;
                  cnt       <= 2'd0;
                  state     <= ENCODE;
               end
            end
            ENCODE: begin
               // zero digits leave their product register untouched
               if (is_zero) begin
                  zero_mask[cnt] <= 1'b1;
               end else begin
                  unique case (cnt)
                     2'd0: pp1 <= prod;
                     2'd1: pp2 <= prod;
                     2'd2: pp3 <= prod;
                     2'd3: pp4 <= prod;
                  endcase
               end
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
